// File: rtl/sysid_probe_ctrl.sv
// Probes an Avalon-MM sysid slave: reads the ID and timestamp words, compares them
// against the expected values, and retries on a mismatch or a read timeout.
module sysid_probe_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd2899645186,
  parameter logic [31:0] EXPECTED_TS    = 32'd1444304653,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [1:0]  retry_cnt
);

  localparam int unsigned WAIT_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RETRY_W = 2;

  localparam logic [WAIT_W-1:0]  TIMEOUT_LIM = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    RD_TS = 3'd2,
    CHECK = 3'd3,
    RETRY = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                pass_d, fail_d, timeout_err_d;
  logic [RETRY_W-1:0]  retry_cnt_d;
  logic [DATA_W-1:0]   id_value_d, ts_value_d;
  logic                read_d, address_d, busy_d, done_d;
  logic                tmo_hit;

  // Stall with the counter already at the limit ends the read; a completion at the limit wins.
  assign tmo_hit = avm_waitrequest && (wait_cnt_q == TIMEOUT_LIM);

  // State and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout_err <= 1'b0;
      retry_cnt   <= '0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      avm_read    <= read_d;
      avm_address <= address_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      fail        <= fail_d;
      timeout_err <= timeout_err_d;
      retry_cnt   <= retry_cnt_d;
      id_value    <= id_value_d;
      ts_value    <= ts_value_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    pass_d        = pass;
    fail_d        = fail;
    timeout_err_d = timeout_err;
    retry_cnt_d   = retry_cnt;
    id_value_d    = id_value;
    ts_value_d    = ts_value;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pass_d        = 1'b0;
          fail_d        = 1'b0;
          timeout_err_d = 1'b0;
          retry_cnt_d   = '0;
          state_d       = RD_ID;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          id_value_d = avm_readdata;
          state_d    = RD_TS;
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
          state_d       = RETRY;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          ts_value_d = avm_readdata;
          state_d    = CHECK;
        end else if (tmo_hit) begin
          timeout_err_d = 1'b1;
          state_d       = RETRY;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      CHECK: begin
        if ((id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS)) begin
          pass_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RETRY;
        end
      end
      RETRY: begin
        if (retry_cnt < RETRY_LIM) begin
          retry_cnt_d = retry_cnt + RETRY_W'(1);
          state_d     = RD_ID;
        end else begin
          fail_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    read_d    = (state_d == RD_ID) || (state_d == RD_TS);
    address_d = (state_d == RD_TS);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
  end

endmodule

// File: tb/tb_sysid_probe_ctrl.sv
// Directed bench for sysid_probe_ctrl with a small Avalon-MM sysid slave model.
module tb_sysid_probe_ctrl;

  localparam logic [31:0] GOOD_ID = 32'd2899645186;
  localparam logic [31:0] GOOD_TS = 32'd1444304653;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        busy, done, pass, fail, timeout_err;
  logic [31:0] id_value, ts_value;
  logic [1:0]  retry_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Slave model configuration and observation.
  int          slave_waits = 0;
  logic [31:0] slave_w0 = GOOD_ID;
  logic [31:0] slave_w1 = GOOD_TS;
  int          stuck_id = 0;
  bit          stall_ts = 1'b0;
  int          wcnt = 0;
  int          pairs = 0;
  int          nlog = 0;
  bit          addr_log [8];
  int          addr_glitch = 0;
  bit          prev_stall = 1'b0;
  logic        prev_addr = 1'b0;
  int          done_count = 0;

  sysid_probe_ctrl #(
    .EXPECTED_ID   (GOOD_ID),
    .EXPECTED_TS   (GOOD_TS),
    .TIMEOUT_CYCLES(8),
    .MAX_RETRIES   (3)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail           (fail),
    .timeout_err    (timeout_err),
    .id_value       (id_value),
    .ts_value       (ts_value),
    .retry_cnt      (retry_cnt)
  );

  always #5 clock = ~clock;

  // Slave responds mid-cycle so its outputs are settled for the next rising edge.
  always @(negedge clock) begin
    if (reset) begin
      wcnt = 0;
      avm_waitrequest = 1'b0;
    end else if (avm_read) begin
      avm_waitrequest = (stall_ts && avm_address) || (stuck_id > 0 && !avm_address)
                        || (wcnt < slave_waits);
      avm_readdata = avm_waitrequest ? 32'hBAD0_BAD0 : (avm_address ? slave_w1 : slave_w0);
      if (prev_stall && avm_address !== prev_addr) addr_glitch++;
      if (avm_waitrequest) wcnt++;
      else begin
        wcnt = 0;
        if (avm_address) pairs++;
        if (nlog < 8) addr_log[nlog] = avm_address;
        nlog++;
      end
    end else begin
      avm_waitrequest = 1'b0;
      if (wcnt > 0 && stuck_id > 0) stuck_id--;
      wcnt = 0;
    end
    prev_stall = avm_read && avm_waitrequest;
    prev_addr  = avm_address;
    if (done) done_count++;
  end

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (!busy) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_idle: busy still %0b after 300 cycles, required 0", busy);
  endtask

  // Pulses start in an IDLE cycle (cycle 1) and returns the cycle number in which done is seen.
  task automatic run_seq(output int lat);
    wait_idle();
    pairs = 0;
    nlog = 0;
    addr_glitch = 0;
    start = 1'b1;
    lat = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      start = 1'b0;
      lat++;
      if (done) return;
    end
    lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if ({avm_read, avm_address, busy, done, pass, fail, timeout_err} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {avm_read, avm_address, busy, done, pass, fail, timeout_err});
    end
    vectors++;
    if (retry_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_retry_cnt: got %0d expected 0", retry_cnt);
    end
    vectors++;
    if (id_value !== 32'h0 || ts_value !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_values: got id=%h ts=%h expected 0/0", id_value, ts_value);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_zero_wait();
    int lat;
    slave_waits = 0; slave_w0 = GOOD_ID; slave_w1 = GOOD_TS;
    run_seq(lat);
    vectors++;
    if (lat != 5) begin
      miscompares++;
      $display("FAIL zero_wait_latency: got %0d expected 5", lat);
    end
    vectors++;
    if ({pass, fail, timeout_err, retry_cnt} !== 5'b10000) begin
      miscompares++;
      $display("FAIL zero_wait_result: got pass=%b fail=%b tmo=%b retry=%0d expected 1/0/0/0",
               pass, fail, timeout_err, retry_cnt);
    end
    vectors++;
    if (nlog != 2 || addr_log[0] !== 1'b0 || addr_log[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_wait_addr_order: got n=%0d a0=%b a1=%b expected 2/0/1",
               nlog, addr_log[0], addr_log[1]);
    end
    vectors++;
    if (id_value !== GOOD_ID || ts_value !== GOOD_TS) begin
      miscompares++;
      $display("FAIL zero_wait_capture: got id=%h ts=%h expected %h/%h",
               id_value, ts_value, GOOD_ID, GOOD_TS);
    end
  endtask

  task automatic test_wait3();
    int lat;
    slave_waits = 3;
    run_seq(lat);
    vectors++;
    if (lat != 11) begin
      miscompares++;
      $display("FAIL wait3_latency: got %0d expected 11", lat);
    end
    vectors++;
    if (pass !== 1'b1 || fail !== 1'b0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL wait3_result: got pass=%b fail=%b tmo=%b expected 1/0/0", pass, fail, timeout_err);
    end
    vectors++;
    if (addr_glitch != 0) begin
      miscompares++;
      $display("FAIL wait3_addr_stable: got %0d address changes during stall expected 0", addr_glitch);
    end
    vectors++;
    if (id_value !== GOOD_ID || ts_value !== GOOD_TS) begin
      miscompares++;
      $display("FAIL wait3_capture: got id=%h ts=%h expected %h/%h", id_value, ts_value, GOOD_ID, GOOD_TS);
    end
  endtask

  task automatic test_timeout_boundary();
    int lat;
    slave_waits = 8;
    run_seq(lat);
    vectors++;
    if (lat != 21) begin
      miscompares++;
      $display("FAIL boundary_latency: got %0d expected 21", lat);
    end
    vectors++;
    if ({pass, fail, timeout_err, retry_cnt} !== 5'b10000) begin
      miscompares++;
      $display("FAIL boundary_result: got pass=%b fail=%b tmo=%b retry=%0d expected 1/0/0/0",
               pass, fail, timeout_err, retry_cnt);
    end
  endtask

  task automatic test_bad_ts();
    int lat;
    slave_waits = 0; slave_w1 = 32'h0;
    run_seq(lat);
    vectors++;
    if (lat != 18) begin
      miscompares++;
      $display("FAIL bad_ts_latency: got %0d expected 18", lat);
    end
    vectors++;
    if (pairs != 4) begin
      miscompares++;
      $display("FAIL bad_ts_pairs: got %0d expected 4", pairs);
    end
    vectors++;
    if ({pass, fail, timeout_err, retry_cnt} !== 5'b01011) begin
      miscompares++;
      $display("FAIL bad_ts_result: got pass=%b fail=%b tmo=%b retry=%0d expected 0/1/0/3",
               pass, fail, timeout_err, retry_cnt);
    end
    vectors++;
    if (ts_value !== 32'h0 || id_value !== GOOD_ID) begin
      miscompares++;
      $display("FAIL bad_ts_capture: got id=%h ts=%h expected %h/0", id_value, ts_value, GOOD_ID);
    end
    slave_w1 = GOOD_TS;
  endtask

  task automatic test_timeout_retry();
    int lat;
    slave_waits = 0; stuck_id = 1;
    run_seq(lat);
    vectors++;
    if (lat < 0) begin
      miscompares++;
      $display("FAIL timeout_retry_done: got no done within bound expected a done pulse");
    end
    vectors++;
    if ({pass, fail, timeout_err, retry_cnt} !== 5'b10101) begin
      miscompares++;
      $display("FAIL timeout_retry_result: got pass=%b fail=%b tmo=%b retry=%0d expected 1/0/1/1",
               pass, fail, timeout_err, retry_cnt);
    end
    stuck_id = 0;
  endtask

  task automatic test_reset_mid_read();
    int dc;
    bit seen = 1'b0;
    wait_idle();
    // Drive the design through a reset so id_value starts from a known zero.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    slave_waits = 0; stall_ts = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (avm_read && avm_address) begin
        seen = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_mid_read_reach: got no RD_TS read expected one");
    end
    dc = done_count;
    reset = 1'b1;
    @(negedge clock);
    stall_ts = 1'b0;
    vectors++;
    if ({avm_read, busy, done} !== 3'b000 || id_value !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_read_state: got read=%b busy=%b done=%b id=%h expected 0/0/0/0",
               avm_read, busy, done, id_value);
    end
    reset = 1'b0;
    repeat (10) @(negedge clock);
    vectors++;
    if (done_count != dc || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_read_no_done: got %0d extra done pulses busy=%b expected 0/0",
               done_count - dc, busy);
    end
  endtask

  task automatic test_start_while_busy();
    int dc;
    slave_waits = 3;
    wait_idle();
    dc = done_count;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_during_seq: got %b expected 1", busy);
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);
    vectors++;
    if (done_count - dc != 1) begin
      miscompares++;
      $display("FAIL start_while_busy: got %0d done pulses expected 1", done_count - dc);
    end
  endtask

  task automatic test_back_to_back();
    int dc;
    slave_waits = 0;
    wait_idle();
    dc = done_count;
    start = 1'b1;
    repeat (6) @(negedge clock);
    start = 1'b0;
    repeat (15) @(negedge clock);
    vectors++;
    if (done_count - dc != 2) begin
      miscompares++;
      $display("FAIL back_to_back: got %0d done pulses expected 2", done_count - dc);
    end
    vectors++;
    if (pass !== 1'b1 || fail !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back_result: got pass=%b fail=%b expected 1/0", pass, fail);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait3();
    test_timeout_boundary();
    test_bad_ts();
    test_timeout_retry();
    test_reset_mid_read();
    test_start_while_busy();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sysid_probe_ctrl.md
SYSID_PROBE_CTRL -- requirements
Module: sysid_probe_ctrl

Interface
REQ-001 The block SHALL have parameter EXPECTED_ID, default 2899645186, which is the required 32-bit value at sysid word 0.
REQ-002 The block SHALL have parameter EXPECTED_TS, default 1444304653, which is the required 32-bit value at sysid word 1.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 255, which is the maximum wait cycles per read; the legal range is 1..65535.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3, which is the number of re-attempts after the first failed pass; the legal range is 0..3.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: request a probe sequence; it is sampled only in IDLE.
REQ-008 The block SHALL have port avm_address, output, 1 bit: Avalon-MM word address to the sysid slave.
REQ-009 The block SHALL have port avm_read, output, 1 bit: Avalon-MM read strobe.
REQ-010 The block SHALL have port avm_waitrequest, input, 1 bit: slave stall; a read completes in the cycle where avm_read=1 and avm_waitrequest=0.
REQ-011 The block SHALL have port avm_readdata, input, 32 bits: read data, valid in the completing cycle.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: a one-cycle pulse at sequence end.
REQ-014 The block SHALL have ports pass and fail, output, 1 bit each: sticky result flags, mutually exclusive.
REQ-015 The block SHALL have port timeout_err, output, 1 bit: sticky; set if any read of the last sequence timed out.
REQ-016 The block SHALL have ports id_value and ts_value, output, 32 bits each: the last captured words 0 and 1.
REQ-017 The block SHALL have port retry_cnt, output, 2 bits: the number of retries used in the current or last sequence.

Function
REQ-018 The FSM SHALL have the states IDLE, RD_ID, RD_TS, CHECK, RETRY, DONE.
REQ-019 In IDLE with start=1, the block SHALL clear pass, fail, timeout_err and retry_cnt, and go to RD_ID on the next cycle.
REQ-020 In RD_ID, the block SHALL drive avm_address=0 and avm_read=1; on completion it SHALL capture avm_readdata into id_value and go to RD_TS.
REQ-021 In RD_TS, the block SHALL drive avm_address=1 and avm_read=1; on completion it SHALL capture avm_readdata into ts_value and go to CHECK.
REQ-022 avm_read SHALL be high only in RD_ID and RD_TS, and SHALL deassert the cycle after completion; avm_address SHALL remain stable while avm_read=1 and avm_waitrequest=1.
REQ-023 A 16-bit wait counter SHALL clear on entry to RD_ID and RD_TS and increment each cycle in which avm_waitrequest=1.
REQ-024 If the wait counter reaches TIMEOUT_CYCLES with avm_waitrequest still 1, the block SHALL drop avm_read, set timeout_err, and go to RETRY without capturing data.
REQ-025 If a completion occurs in the same cycle as the timeout threshold, the completion SHALL win: data is captured and no timeout is recorded.
REQ-026 CHECK SHALL take 1 cycle: if id_value==EXPECTED_ID and ts_value==EXPECTED_TS, the block SHALL set pass and go to DONE; otherwise it SHALL go to RETRY.
REQ-027 In RETRY, if retry_cnt<MAX_RETRIES, the block SHALL increment retry_cnt and go to RD_ID; otherwise it SHALL set fail and go to DONE.
REQ-028 DONE SHALL assert done for exactly 1 cycle and return to IDLE.
REQ-029 start SHALL be ignored while busy=1; start held high SHALL launch a new sequence on each return to IDLE.
REQ-030 Minimum latency with zero wait states SHALL be 5 cycles from start sampled to done (IDLE, RD_ID, RD_TS, CHECK, DONE).
REQ-031 timeout_err SHALL remain set even if a later retry passes; pass=1 together with timeout_err=1 is legal.

Reset
REQ-032 On reset=1 at a clock edge, the state SHALL become IDLE, and avm_read, avm_address, busy, done, pass, fail, timeout_err, retry_cnt, id_value, ts_value and the wait counter SHALL all be 0.
REQ-033 Reset asserted mid-read SHALL drop avm_read on the next edge; no capture SHALL occur, and no done pulse SHALL be issued.

Verification
REQ-034 A directed test SHALL cover a zero-wait slave returning 2899645186 and 1444304653: addresses 0 then 1 are issued, done occurs 5 cycles after start, pass=1, fail=0, retry_cnt=0.
REQ-035 A directed test SHALL cover a slave with 3 wait cycles per read: avm_address is held stable during the stall, done occurs 11 cycles after start, pass=1.
REQ-036 A directed test SHALL cover word 1 returning 0 on every read with MAX_RETRIES=3: 4 read pairs are issued, retry_cnt=3, fail=1, pass=0, and ts_value=0.
REQ-037 A directed test SHALL cover waitrequest stuck at 1 for the first ID read, then zero-wait operation, with TIMEOUT_CYCLES=8: after the timeout, a retry occurs and passes, giving timeout_err=1, pass=1, retry_cnt=1.
REQ-038 A directed test SHALL cover reset during RD_TS with waitrequest=1: the next cycle shows avm_read=0, busy=0, id_value=0, and no done pulse.
REQ-039 A directed test SHALL cover start pulsed again while busy: it is ignored and exactly 1 done pulse is issued.
